// File: rtl/sequence_controller_if.sv
// Shared game-state type and the controller's handshake bundle.
// The random generator and display both consume state_t.
package seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2, WIN = 2'd3} state_t;
endpackage

interface sequence_controller_if;
    import seq_pkg::*;
    logic       start;
    logic [1:0] rnd;
    logic       btn_valid;
    logic [1:0] btn_code;
    state_t     state;
    logic       show_valid;
    logic [1:0] show_code;
    logic [4:0] level;
    logic       rng_hold;

    modport slave (
        input  start, rnd, btn_valid, btn_code,
        output state, show_valid, show_code, level, rng_hold
    );
    modport master (
        output start, rnd, btn_valid, btn_code,
        input  state, show_valid, show_code, level, rng_hold
    );
endinterface

// File: rtl/sequence_controller.sv
// Memory-game sequencer: grows a random 2-bit pattern each round, plays it
// back, then checks player presses against it (RUN / OVER / WIN).
module sequence_controller
    import seq_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sequence_controller_if.slave bus
);
    localparam int TMAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(TMAX);

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHOW, S_GAP, S_WAIT, S_OVER, S_WIN} fsm_t;

    fsm_t          fsm;
    logic [4:0]    len;
    logic [3:0]    idx;
    logic [TW-1:0] timer;
    logic [1:0]    pat_buf [16];

    logic last;
    logic hit;
    assign last = ({1'b0, idx} == len - 5'd1);
    assign hit  = (bus.btn_code == pat_buf[idx]);

    // Pattern storage carries no reset; only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (fsm == S_ADD) pat_buf[len[3:0]] <= bus.rnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            timer <= '0;
        end else begin
            case (fsm)
                S_IDLE, S_OVER, S_WIN: begin
                    if (bus.start) begin
                        len <= '0;
                        fsm <= S_ADD;
                    end
                end
                S_ADD: begin
                    len   <= len + 5'd1;
                    idx   <= '0;
                    timer <= '0;
                    fsm   <= S_SHOW;
                end
                S_SHOW: begin
                    if (timer == TW'(SHOW_CYCLES - 1)) begin
                        timer <= '0;
                        fsm   <= S_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer <= '0;
                        if (last) begin
                            idx <= '0;
                            fsm <= S_WAIT;
                        end else begin
                            idx <= idx + 4'd1;
                            fsm <= S_SHOW;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A press on the timeout cycle takes priority over the timeout.
                    if (bus.btn_valid) begin
                        if (!hit)                        fsm <= S_OVER;
                        else if (!last) begin
                            idx   <= idx + 4'd1;
                            timer <= '0;
                        end
                        else if (len == 5'(MAX_LEN))     fsm <= S_WIN;
                        else                             fsm <= S_ADD;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        fsm <= S_OVER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.show_valid = (fsm == S_SHOW);
    assign bus.show_code  = (fsm == S_SHOW) ? pat_buf[idx] : 2'b00;
    assign bus.level      = len;
    assign bus.rng_hold   = (fsm == S_ADD);

    always_comb begin
        bus.state = RUN;
        case (fsm)
            S_IDLE:  bus.state = IDLE;
            S_OVER:  bus.state = OVER;
            S_WIN:   bus.state = WIN;
            default: bus.state = RUN;
        endcase
    end
endmodule

// File: tb/tb_sequence_controller.sv
// Directed bench for sequence_controller: expected output snapshots are
// queued as stimulus is applied and popped/compared after each clock edge.
module tb_sequence_controller;
    import seq_pkg::*;

    logic clk;
    logic rst_n;
    sequence_controller_if bus();

    sequence_controller #(
        .MAX_LEN(3), .SHOW_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [10:0] snap();
        return {bus.state, bus.show_valid, bus.show_code, bus.level, bus.rng_hold};
    endfunction

    task automatic push(input string tag, input state_t st, input logic sv,
                        input logic [1:0] sc, input logic [4:0] lv, input logic rh);
        exp_t e;
        e.tag = tag;
        e.val = {st, sv, sc, lv, rh};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [10:0] obs;
        e   = sb.pop_front();
        obs = snap();
        n_cmp++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed st/sv/sc/lv/rh=%h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input string tag, input state_t st, input logic sv,
                       input logic [1:0] sc, input logic [4:0] lv, input logic rh);
        push(tag, st, sv, sc, lv, rh);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.btn_valid = 1'b0;
        check();
    endtask

    task automatic press(input logic [1:0] code);
        bus.btn_valid = 1'b1;
        bus.btn_code  = code;
    endtask

    // Playback of n symbols (p[0] first): 2 cycles shown, 1 blank, then into WAIT.
    task automatic play(input int n, input logic [2:0][1:0] p, input logic [4:0] lv);
        for (int i = 0; i < n; i++) begin
            cyc("show_a", RUN, 1'b1, p[i], lv, 1'b0);
            cyc("show_b", RUN, 1'b1, p[i], lv, 1'b0);
            cyc("gap",    RUN, 1'b0, 2'b00, lv, 1'b0);
        end
        cyc("enter_wait", RUN, 1'b0, 2'b00, lv, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.rnd = 2'b00; bus.btn_valid = 1'b0; bus.btn_code = 2'b00;
        rst_n = 1'b0;
        #3;
        push("reset", IDLE, 1'b0, 2'b00, 5'd0, 1'b0);
        check();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("idle", IDLE, 1'b0, 2'b00, 5'd0, 1'b0);

        // First round
        bus.start = 1'b1; bus.rnd = 2'b01;
        cyc("add1", RUN, 1'b0, 2'b00, 5'd0, 1'b1);
        play(1, {2'b00, 2'b00, 2'b01}, 5'd1);

        // Round 1: correct press grows pattern with 10
        bus.rnd = 2'b10; press(2'b01);
        cyc("r1_add", RUN, 1'b0, 2'b00, 5'd1, 1'b1);
        play(2, {2'b00, 2'b10, 2'b01}, 5'd2);

        // Round 2: wrong second press -> OVER, further presses ignored
        press(2'b01);
        cyc("r2_p0", RUN, 1'b0, 2'b00, 5'd2, 1'b0);
        press(2'b11);
        cyc("r2_wrong", OVER, 1'b0, 2'b00, 5'd2, 1'b0);
        press(2'b01);
        cyc("over_ign", OVER, 1'b0, 2'b00, 5'd2, 1'b0);
        cyc("over_hold", OVER, 1'b0, 2'b00, 5'd2, 1'b0);

        // Full game to WIN with pattern 01,10,00
        bus.start = 1'b1; bus.rnd = 2'b01;
        cyc("restart", RUN, 1'b0, 2'b00, 5'd0, 1'b1);
        play(1, {2'b00, 2'b00, 2'b01}, 5'd1);
        bus.rnd = 2'b10; press(2'b01);
        cyc("w_add2", RUN, 1'b0, 2'b00, 5'd1, 1'b1);
        play(2, {2'b00, 2'b10, 2'b01}, 5'd2);
        press(2'b01);
        cyc("w2_p0", RUN, 1'b0, 2'b00, 5'd2, 1'b0);
        bus.rnd = 2'b00; press(2'b10);
        cyc("w_add3", RUN, 1'b0, 2'b00, 5'd2, 1'b1);
        play(3, {2'b00, 2'b10, 2'b01}, 5'd3);
        press(2'b01);
        cyc("w3_p0", RUN, 1'b0, 2'b00, 5'd3, 1'b0);
        press(2'b10);
        cyc("w3_p1", RUN, 1'b0, 2'b00, 5'd3, 1'b0);
        press(2'b00);
        cyc("win", WIN, 1'b0, 2'b00, 5'd3, 1'b0);
        cyc("win_hold", WIN, 1'b0, 2'b00, 5'd3, 1'b0);
        bus.start = 1'b1; bus.rnd = 2'b01;
        cyc("win_restart", RUN, 1'b0, 2'b00, 5'd0, 1'b1);
        play(1, {2'b00, 2'b00, 2'b01}, 5'd1);

        // Timeout: OVER on the edge where timer==7
        for (int i = 0; i < 7; i++) cyc("to_wait", RUN, 1'b0, 2'b00, 5'd1, 1'b0);
        cyc("timeout", OVER, 1'b0, 2'b00, 5'd1, 1'b0);

        // Correct press on the timeout cycle wins and restarts the timer
        bus.start = 1'b1; bus.rnd = 2'b01;
        cyc("t_add1", RUN, 1'b0, 2'b00, 5'd0, 1'b1);
        play(1, {2'b00, 2'b00, 2'b01}, 5'd1);
        bus.rnd = 2'b10; press(2'b01);
        cyc("t_add2", RUN, 1'b0, 2'b00, 5'd1, 1'b1);
        play(2, {2'b00, 2'b10, 2'b01}, 5'd2);
        for (int i = 0; i < 7; i++) cyc("t_idle_a", RUN, 1'b0, 2'b00, 5'd2, 1'b0);
        press(2'b01);
        cyc("late_press", RUN, 1'b0, 2'b00, 5'd2, 1'b0);
        for (int i = 0; i < 7; i++) cyc("t_idle_b", RUN, 1'b0, 2'b00, 5'd2, 1'b0);
        bus.rnd = 2'b00; press(2'b10);
        cyc("timer_rst", RUN, 1'b0, 2'b00, 5'd2, 1'b1);
        cyc("show_pre_rst", RUN, 1'b1, 2'b01, 5'd3, 1'b0);

        // Asynchronous reset mid-show
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", IDLE, 1'b0, 2'b00, 5'd0, 1'b0);
        check();
        @(posedge clk);
        #1 rst_n = 1'b1;
        press(2'b01);
        cyc("idle_btn_a", IDLE, 1'b0, 2'b00, 5'd0, 1'b0);
        press(2'b10);
        cyc("idle_btn_b", IDLE, 1'b0, 2'b00, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Game-sequencing controller for the team_08 memory game. Drives the shared `state_t` bus that the random generator consumes.
- Appends one 2-bit random symbol per round to an internal pattern buffer, then plays the pattern back on the display outputs.
- Collects player button presses, checks each against the stored pattern, and decides RUN / OVER / WIN.

Parameters:
- MAX_LEN, 16, pattern length that produces WIN (2..16)
- SHOW_CYCLES, 8, clk cycles each symbol is displayed (>=1)
- GAP_CYCLES, 4, blank clk cycles after each displayed symbol (>=1)
- TIMEOUT_CYCLES, 64, clk cycles allowed between presses in input phase (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start/restart pulse
- rnd  in  2  random symbol from random generator
- btn_valid  in  1  one-cycle pulse: player pressed a button
- btn_code  in  2  symbol of pressed button; valid with btn_valid
- state  out  state_t  game state to random generator and display: IDLE, RUN, OVER, WIN
- show_valid  out  1  high while a pattern symbol is displayed
- show_code  out  2  symbol being displayed; 0 when show_valid=0
- level  out  5  current pattern length, 0..MAX_LEN
- rng_hold  out  1  one-cycle pulse in ADD; drives the generator's button_pressed input to restart its dividers

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous, active-low.
  - On reset: FSM=S_IDLE, state=IDLE, len=0, idx=0, timers=0. show_valid=0, show_code=0, level=0, rng_hold=0.
  - Buffer contents are don't-care after reset.
- Internal FSM: S_IDLE, S_ADD, S_SHOW, S_GAP, S_WAIT, S_OVER, S_WIN.
- state output mapping:
  - S_IDLE -> IDLE
  - S_OVER -> OVER
  - S_WIN -> WIN
  - all other FSM states -> RUN
  - All outputs are registered or decoded from registered FSM state.
- S_IDLE: on start, len<=0, next S_ADD.
- S_ADD (exactly 1 cycle):
  - buf[len]<=rnd sampled this cycle; len<=len+1; idx<=0; timer<=0; rng_hold=1.
  - Next S_SHOW.
- S_SHOW:
  - show_valid=1, show_code=buf[idx].
  - Lasts exactly SHOW_CYCLES cycles, then S_GAP with timer<=0.
- S_GAP:
  - show_valid=0; lasts exactly GAP_CYCLES cycles.
  - Then, if idx==len-1: idx<=0, timer<=0, next S_WAIT.
  - Otherwise idx<=idx+1, next S_SHOW.
- S_WAIT: timer increments each cycle without btn_valid.
  - btn_valid and btn_code==buf[idx]:
    - idx<len-1: idx<=idx+1, timer<=0.
    - idx==len-1 and len==MAX_LEN: next S_WIN.
    - idx==len-1 and len<MAX_LEN: next S_ADD.
  - btn_valid and mismatch: next S_OVER.
  - No press and timer==TIMEOUT_CYCLES-1: next S_OVER.
  - btn_valid on the timeout cycle: the press wins; it is evaluated, timeout ignored.
- S_OVER / S_WIN: hold until start, then len<=0, next S_ADD (direct restart, no pass through S_IDLE).
- Ignored inputs:
  - btn_valid outside S_WAIT: ignored, no state change.
  - start outside S_IDLE/S_OVER/S_WIN: ignored.
- level = len at all times. It never exceeds MAX_LEN and never wraps; S_WIN is entered before len can grow past MAX_LEN.
- Latency checks:
  - First show_valid rises 2 cycles after the start pulse cycle.
  - A wrong press reaches OVER on the next clk edge.
- Reset asserted mid-round: immediate asynchronous return to S_IDLE. The pattern is discarded (len=0).

Test Plan:
- Common bench parameters: MAX_LEN=3, SHOW_CYCLES=2, GAP_CYCLES=1, TIMEOUT_CYCLES=8.
- Reset then start with rnd=2'b01 -> state IDLE->RUN; level=1; show_valid high 2 cycles with show_code=01, then low 1 cycle; FSM in S_WAIT.
- Round 1, press 01 -> S_ADD with rnd=10 -> level=2; playback 01 then 10, each 2 cycles on / 1 off; rng_hold pulses once.
- Round 2, press 01 then 11 -> state=OVER on the edge after the second press; level stays 2; further btn_valid ignored.
- Correct presses through level 3 (pattern 01,10,00) -> state=WIN after the third correct press; start then -> RUN, level=1.
- In S_WAIT, no press for 8 cycles -> OVER exactly at timer=7. Repeat with btn_valid correct on cycle 7 -> no OVER, idx advances.
- Assert rst_n low during S_SHOW -> same-cycle state=IDLE, show_valid=0, level=0. btn_valid pulses while in IDLE -> no change.
